// File: rtl/fetch_sequencer.sv
// Stage-1 fetch controller: PC stall/select, single-outstanding imem handshake, stage-2 redirects.
// Optional perf counters are enabled with `define FETCH_PERF_EN.
module fetch_sequencer
`ifdef FETCH_PERF_EN
  #(parameter int unsigned CNT_W = 32)
`endif
  (
  input  logic clk,
  input  logic reset_n,
  input  logic redirect_valid,
  input  logic dmem_stall,
  input  logic imem_req_ready,
  input  logic imem_resp_valid,
  output logic imem_req_valid,
  output logic pc_stall,
  output logic pc_sel,
  output logic inst_valid,
  output logic redirect_taken
`ifdef FETCH_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cyc,
  output logic [CNT_W-1:0] perf_redirects
`endif
);

  typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t state, state_nxt;
  logic   drop_pending, drop_nxt;
  logic   rd;

  assign rd = redirect_valid & ~dmem_stall;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= S_BOOT;
      drop_pending <= 1'b0;
    end else begin
      state        <= state_nxt;
      drop_pending <= drop_nxt;
    end
  end

  always_comb begin
    imem_req_valid = 1'b0;
    pc_stall       = 1'b1;
    pc_sel         = 1'b0;
    inst_valid     = 1'b0;
    redirect_taken = 1'b0;
    state_nxt      = state;
    drop_nxt       = drop_pending;

    // Outputs stay at their safe defaults while reset is asserted, whatever the state.
    if (reset_n) begin
      case (state)
        S_BOOT: state_nxt = S_REQ;

        S_REQ: begin
          if (rd) begin
            pc_stall       = 1'b0;
            pc_sel         = 1'b1;
            redirect_taken = 1'b1;
          end else begin
            imem_req_valid = ~dmem_stall & ~redirect_valid;
            if (~dmem_stall & ~redirect_valid & imem_req_ready) begin
              pc_stall  = 1'b0;
              state_nxt = S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if (rd) begin
            pc_stall       = 1'b0;
            pc_sel         = 1'b1;
            redirect_taken = 1'b1;
            // A response in the redirect cycle is dropped right here; otherwise mark it for dropping.
            if (imem_resp_valid) begin
              drop_nxt  = 1'b0;
              state_nxt = S_REQ;
            end else begin
              drop_nxt  = 1'b1;
            end
          end else if (imem_resp_valid) begin
            if (drop_pending) begin
              drop_nxt  = 1'b0;
              state_nxt = S_REQ;
            end else if (!dmem_stall) begin
              inst_valid = 1'b1;
              state_nxt  = S_REQ;
            end else begin
              state_nxt  = S_HOLD;
            end
          end
        end

        S_HOLD: begin
          inst_valid = 1'b1;
          if (rd) begin
            inst_valid     = 1'b0;
            pc_stall       = 1'b0;
            pc_sel         = 1'b1;
            redirect_taken = 1'b1;
            state_nxt      = S_REQ;
          end else if (!dmem_stall) begin
            state_nxt = S_REQ;
          end
        end

        default: state_nxt = S_BOOT;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_stall_cyc <= '0;
      perf_redirects <= '0;
    end else begin
      if (pc_stall && state != S_BOOT && perf_stall_cyc != '1)
        perf_stall_cyc <= perf_stall_cyc + 1'b1;
      if (redirect_taken && perf_redirects != '1)
        perf_redirects <= perf_redirects + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed vector table plus hand-written multi-cycle sequences for fetch_sequencer.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  logic reset_n, redirect_valid, dmem_stall, imem_req_ready, imem_resp_valid;
  logic imem_req_valid, pc_stall, pc_sel, inst_valid, redirect_taken;
`ifdef FETCH_PERF_EN
  logic [3:0] perf_stall_cyc, perf_redirects;
`endif

  always #5 clk = ~clk;

`ifdef FETCH_PERF_EN
  fetch_sequencer #(.CNT_W(4)) dut (
`else
  fetch_sequencer dut (
`endif
    .clk(clk), .reset_n(reset_n), .redirect_valid(redirect_valid),
    .dmem_stall(dmem_stall), .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_req_valid(imem_req_valid),
    .pc_stall(pc_stall), .pc_sel(pc_sel), .inst_valid(inst_valid),
    .redirect_taken(redirect_taken)
`ifdef FETCH_PERF_EN
    , .perf_stall_cyc(perf_stall_cyc), .perf_redirects(perf_redirects)
`endif
  );

  // in  = {reset_n, redirect_valid, dmem_stall, imem_req_ready, imem_resp_valid}
  // exp = {imem_req_valid, pc_stall, pc_sel, inst_valid, redirect_taken}
  typedef struct packed {
    logic [4:0] in;
    logic [4:0] exp;
  } vec_t;

  localparam int unsigned NV = 40;
  vec_t tbl [NV];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] in);
    {reset_n, redirect_valid, dmem_stall, imem_req_ready, imem_resp_valid} = in;
  endtask

  function automatic logic [4:0] outs();
    return {imem_req_valid, pc_stall, pc_sel, inst_valid, redirect_taken};
  endfunction

  initial begin
    int iv_cnt, adv_cnt, k;

    // reset held 3 cycles, response during reset and BOOT ignored
    tbl[0]  = '{5'b00000, 5'b01000};
    tbl[1]  = '{5'b00000, 5'b01000};
    tbl[2]  = '{5'b00011, 5'b01000};
    tbl[3]  = '{5'b10011, 5'b01000};  // BOOT
    tbl[4]  = '{5'b10010, 5'b10000};  // REQ fire
    tbl[5]  = '{5'b10001, 5'b01010};  // WAIT resp -> inst_valid
    tbl[6]  = '{5'b10010, 5'b10000};
    tbl[7]  = '{5'b10001, 5'b01010};
    tbl[8]  = '{5'b10000, 5'b11000};  // REQ not ready
    tbl[9]  = '{5'b10100, 5'b01000};  // REQ under dmem_stall
    tbl[10] = '{5'b10010, 5'b10000};
    tbl[11] = '{5'b10000, 5'b01000};  // WAIT idle
    tbl[12] = '{5'b11000, 5'b00101};  // redirect in WAIT -> drop pending
    tbl[13] = '{5'b10000, 5'b01000};
    tbl[14] = '{5'b10001, 5'b01000};  // response discarded
    tbl[15] = '{5'b10010, 5'b10000};
    tbl[16] = '{5'b10101, 5'b01000};  // resp + stall -> HOLD
    tbl[17] = '{5'b10100, 5'b01010};
    tbl[18] = '{5'b10100, 5'b01010};
    tbl[19] = '{5'b11100, 5'b01010};  // redirect ignored under stall
    tbl[20] = '{5'b10010, 5'b01010};  // consumed, -> REQ
    tbl[21] = '{5'b10010, 5'b10000};
    tbl[22] = '{5'b11001, 5'b00101};  // resp together with redirect
    tbl[23] = '{5'b10010, 5'b10000};
    tbl[24] = '{5'b10001, 5'b01010};  // not dropped: drop_pending stayed 0
    tbl[25] = '{5'b11010, 5'b00101};  // redirect beats ready in REQ
    tbl[26] = '{5'b10010, 5'b10000};
    tbl[27] = '{5'b10101, 5'b01000};
    tbl[28] = '{5'b11000, 5'b00101};  // redirect kills HOLD instruction
    tbl[29] = '{5'b10000, 5'b11000};
    tbl[30] = '{5'b10001, 5'b11000};  // stray resp in REQ ignored
    tbl[31] = '{5'b10010, 5'b10000};
    tbl[32] = '{5'b11000, 5'b00101};
    tbl[33] = '{5'b11000, 5'b00101};  // second redirect while pending
    tbl[34] = '{5'b10001, 5'b01000};
    tbl[35] = '{5'b10010, 5'b10000};
    tbl[36] = '{5'b11100, 5'b01000};  // WAIT, stalled redirect ignored
    tbl[37] = '{5'b00000, 5'b01000};  // reset mid-request
    tbl[38] = '{5'b10001, 5'b01000};  // BOOT ignores late resp
    tbl[39] = '{5'b10000, 5'b11000};

    for (int i = 0; i < int'(NV); i++) begin
      @(negedge clk);
      drive(tbl[i].in);
      #2;
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
    end

    // streaming: always ready, response one cycle after each accept
    iv_cnt = 0;
    adv_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive({4'b1001, 1'(i % 2)});
      #2;
      chk($sformatf("stream_iv%0d", i), 32'(inst_valid), 32'(i % 2));
      if (inst_valid) iv_cnt++;
      if (!pc_stall) adv_cnt++;
    end
    chk("stream_fetches", 32'(iv_cnt), 32'd10);
    chk("stream_pc_adv", 32'(adv_cnt), 32'd10);

    // reset release: first request on the second cycle after release
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(5'b00010);
    end
    k = 6;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(5'b10000);
      #2;
      if (imem_req_valid) begin
        k = i;
        break;
      end
    end
    chk("first_req_cycle", 32'(k), 32'd1);

`ifdef FETCH_PERF_EN
    @(negedge clk);
    drive(5'b00000);
    @(negedge clk);
    drive(5'b10100);  // BOOT, not counted
    #2;
    chk("perf_stall_rst", 32'(perf_stall_cyc), 32'd0);
    chk("perf_redir_rst", 32'(perf_redirects), 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(5'b10100);
    end
    @(negedge clk);
    drive(5'b11000);  // redirect in REQ
    #2;
    chk("perf_stall_sat", 32'(perf_stall_cyc), 32'd15);
    @(negedge clk);
    drive(5'b10000);
    #2;
    chk("perf_redirects", 32'(perf_redirects), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
